pio_edge_irq: RTL and testbench
===============================

Name: pio_edge_irq

Overview:
- Parametrised general-purpose Avalon-MM PIO slave; next generation of the fixed 16-bit output-only PIO in the Nios subsystems.
- Adds per-bit direction control, a synchronised input path, edge capture and a maskable level interrupt to the Nios IRQ line.
- Adds atomic bit set/clear on the output register.
- Sits on the Nios data master bus beside the existing PIOs; drives board LEDs/headers and samples switches/buttons.

Parameters:
- WIDTH, 16, port width in bits, legal range 1..32.
- RESET_VALUE, 0, reset value of data_out, WIDTH bits.
- DIR_RESET, 0, reset value of the direction register, 1 = output.
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on clk rising edge.
- address  in  3  register word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  read data, combinational from address; zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  registered output data.
- out_en  out  WIDTH  per-bit output enable (direction register).
- irq  out  1  level interrupt, active high.

Behaviour:
- Register map (word offsets); a write happens when chipselect=1 and write_n=0:
  - 0 DATA: read = (in_sync & ~dir) | (data_out & dir); write loads data_out.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; write-1-to-clear.
  - 4 OUTSET: write data_out |= wd; reads 0.
  - 5 OUTCLR: write data_out &= ~wd; reads 0.
  - 6,7: read 0; writes ignored.
- Reset, synchronous with reset_n=0 at the clk edge:
  - data_out=RESET_VALUE; dir=DIR_RESET; irqmask=0; edgecap=0.
  - Sync flops and the previous-sample flop are 0.
  - Resulting outputs: out_port=RESET_VALUE, out_en=DIR_RESET, irq=0.
  - Reset asserted mid-operation discards any same-cycle write.
- Write latency: the register updates on the clk edge of the write; out_port and out_en change in the following cycle.
- Read latency: 0 cycles, combinational; readdata is valid in the same cycle as address.
- Input path:
  - Two-flop synchroniser in_sync, then one further flop in_prev.
  - Edge detect compares in_sync with in_prev.
  - Earliest detection: 2 clocks after in_port changes; edgecap bit set on the 3rd edge.
- Edge detect and capture:
  - Rising edge: in_sync & ~in_prev. Falling edge: ~in_sync & in_prev. Any edge: XOR.
  - Capture applies to all bits regardless of dir.
  - edgecap bit is sticky until cleared.
  - Same cycle, clear-write plus new edge on the same bit: the set wins and the bit stays 1, so no edge is lost.
  - Clear of an unset bit has no effect.
- irq = |(edgecap & irqmask), registered-free OR of register outputs; it follows the mask immediately.
- OUTSET and OUTCLR are single-cycle read-modify-write with no hazard. Back-to-back writes on consecutive cycles each apply to the updated value.
- WIDTH=32: no zero-extension bits. Bits of writedata above WIDTH are ignored on every register.

Decomposition:
- Shared package pio_pkg:
  - Register offset constants ADDR_DATA..ADDR_OUTCLR.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY constants.
  - Helper for zero-extension to 32.
- One sub-module pio_edge_detect, params WIDTH and EDGE_TYPE:
  - Contains the synchroniser, the previous-sample flop and the edge pulse logic.
  - Inputs clk, reset_n, in_port; outputs in_sync and edge_pulse.
- The top level holds the registers, the read mux and irq.

Test Plan (WIDTH=16, EDGE_TYPE=0 unless stated):
- Reset, then read offsets 0..7 with in_port=0 -> out_port=0x0000, out_en=0x0000, irq=0, all readdata 0. Write DATA=0x1234 during reset_n=0 -> out_port remains 0x0000.
- Output and read mux:
  - Write DIR=0x00FF, DATA=0xA5C3, in_port=0x5A00, wait 3 clk, read DATA -> 0x5AC3.
  - Write DATA=0xFFFFA5C3 -> out_port=0xA5C3, upper bits ignored.
- Set/clear with DATA=0x00F0:
  - OUTSET 0x0F00 -> out_port=0x0FF0.
  - OUTCLR 0x0030 on the next cycle -> 0x0FC0.
  - Read OUTSET -> 0.
- Edge capture and irq:
  - IRQMASK=0x0001, pulse in_port[0] 0->1 -> EDGECAP=0x0001 on the 3rd clk edge; irq=1 the same cycle.
  - Write EDGECAP=0x0001 -> EDGECAP=0, irq=0.
- Mask and collision:
  - Rising edge on bit 4 with IRQMASK=0 -> EDGECAP=0x0010, irq=0.
  - Then IRQMASK=0x0010 -> irq=1 next cycle.
  - Clear bit 4 in the same cycle a new bit-4 edge is detected -> EDGECAP stays 0x0010.
- EDGE_TYPE=1 and EDGE_TYPE=2 builds:
  - in_port[2] 1->0 -> bit 2 captured in both builds.
  - in_port[2] 0->1 -> bit 2 captured only in the EDGE_TYPE=2 build.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared register offsets, edge-mode constants and read-data helper for the PIO slave.
// Pure declarations: no latency or backpressure of its own.
package pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   // Keeps only the low w bits so the bus never sees stale bits above the port width.
   function automatic logic [31:0] zext32(input logic [31:0] v, input int unsigned w);
      logic [31:0] m;
      m = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      return v & m;
   endfunction

endpackage

// File: rtl/pio_edge_irq_if.sv
// Avalon-MM slave bus bundle for the PIO: word address, strobes, write and read data.
// Reads are combinational; the slave never stalls, so there is no waitrequest.
interface pio_edge_irq_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/pio_edge_detect.sv
// Two-flop input synchroniser plus previous-sample flop; edge_pulse is valid 2 clocks after in_port moves.
// No backpressure: a pulse lasts exactly one cycle and must be captured by the parent.
module pio_edge_detect
   import pio_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int EDGE_TYPE = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] in_sync,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] in_prev;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1   <= '0;
         in_sync <= '0;
         in_prev <= '0;
      end else begin
         sync1   <= in_port;
         in_sync <= sync1;
         in_prev <= in_sync;
      end
   end

   generate
      if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
         assign edge_pulse = ~in_sync & in_prev;
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
         assign edge_pulse = in_sync ^ in_prev;
      end else begin : g_rise
         assign edge_pulse = in_sync & ~in_prev;
      end
   endgenerate

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM PIO: data/direction registers, atomic set/clear, sticky edge capture and maskable level irq.
// Writes land on the strobe's clock edge, reads are 0-cycle combinational, and the slave never stalls.
module pio_edge_irq
   import pio_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '0,
   parameter int               EDGE_TYPE   = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset_n,
   pio_edge_irq_if.slave    bus,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] out_en,
   output logic             irq
);

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] edge_pulse;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] ecap_clr;
   logic [WIDTH-1:0] rd_val;
   logic             wr_en;
   logic             unused_wd;

   pio_edge_detect #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (EDGE_TYPE)
   ) u_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .in_sync    (in_sync),
      .edge_pulse (edge_pulse)
   );

   assign wr_en     = bus.chipselect & ~bus.write_n;
   assign wd        = bus.writedata[WIDTH-1:0];
   assign unused_wd = ^bus.writedata;
   assign ecap_clr  = (wr_en && bus.address == ADDR_EDGECAP) ? wd : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_out <= RESET_VALUE;
         dir      <= DIR_RESET;
         irqmask  <= '0;
         edgecap  <= '0;
      end else begin
         if (wr_en) begin
            case (bus.address)
               ADDR_DATA:    data_out <= wd;
               ADDR_DIR:     dir      <= wd;
               ADDR_IRQMASK: irqmask  <= wd;
               ADDR_OUTSET:  data_out <= data_out | wd;
               ADDR_OUTCLR:  data_out <= data_out & ~wd;
               default: ;
            endcase
         end
         // A new edge outranks a same-cycle clear so no event is ever dropped.
         edgecap <= (edgecap & ~ecap_clr) | edge_pulse;
      end
   end

   always_comb begin
      rd_val = '0;
      case (bus.address)
         ADDR_DATA:    rd_val = (in_sync & ~dir) | (data_out & dir);
         ADDR_DIR:     rd_val = dir;
         ADDR_IRQMASK: rd_val = irqmask;
         ADDR_EDGECAP: rd_val = edgecap;
         default:      rd_val = '0;
      endcase
   end

   assign bus.readdata = zext32(32'(rd_val), WIDTH);
   assign out_port     = data_out;
   assign out_en       = dir;
   assign irq          = |(edgecap & irqmask);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Bench for pio_edge_irq: rising, falling and any-edge builds share one bus and one input port.
// A sample-history model predicts every register, output and read value on every clock.
module tb_pio_edge_irq;
   import pio_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [2:0]   address;
   logic         chipselect;
   logic         write_n;
   logic [31:0]  writedata;
   logic [W-1:0] in_port;

   logic [W-1:0] out_port [3];
   logic [W-1:0] out_en   [3];
   logic         irq      [3];
   logic [31:0]  rd       [3];

   int errors = 0;
   int checks = 0;

   // Expected register state per build, and in_port as sampled at the last four edges (index 0 newest).
   logic [W-1:0] m_data [3];
   logic [W-1:0] m_dir  [3];
   logic [W-1:0] m_mask [3];
   logic [W-1:0] m_cap  [3];
   logic [W-1:0] s      [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      pio_edge_irq_if bus_i ();
      assign bus_i.address    = address;
      assign bus_i.chipselect = chipselect;
      assign bus_i.write_n    = write_n;
      assign bus_i.writedata  = writedata;
      assign rd[g]            = bus_i.readdata;

      pio_edge_irq #(
         .WIDTH       (W),
         .RESET_VALUE (16'h0000),
         .DIR_RESET   (16'h0000),
         .EDGE_TYPE   (g)
      ) u_dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .bus      (bus_i),
         .in_port  (in_port),
         .out_port (out_port[g]),
         .out_en   (out_en[g]),
         .irq      (irq[g])
      );
   end

   function automatic logic [W-1:0] edges(int mode, logic [W-1:0] nw, logic [W-1:0] old);
      case (mode)
         0:       return nw & ~old;
         1:       return ~nw & old;
         default: return nw ^ old;
      endcase
   endfunction

   // in_sync is the sample taken one edge before the newest one.
   function automatic logic [31:0] exp_rd(int b, logic [2:0] a);
      case (a)
         3'd0:    return 32'((s[1] & ~m_dir[b]) | (m_data[b] & m_dir[b]));
         3'd1:    return 32'(m_dir[b]);
         3'd2:    return 32'(m_mask[b]);
         3'd3:    return 32'(m_cap[b]);
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int b = 0; b < 3; b++) begin
         chk($sformatf("out_port[%0d]", b), 32'(out_port[b]), 32'(m_data[b]));
         chk($sformatf("out_en[%0d]", b), 32'(out_en[b]), 32'(m_dir[b]));
         chk($sformatf("irq[%0d]", b), 32'(irq[b]), 32'(|(m_cap[b] & m_mask[b])));
         chk($sformatf("readdata[%0d]@%0d", b, address), rd[b], exp_rd(b, address));
      end
   endtask

   task automatic tick();
      logic         wr;
      logic [W-1:0] wd;
      logic [W-1:0] clr;
      wr  = chipselect && !write_n;
      wd  = writedata[W-1:0];
      clr = (wr && address == ADDR_EDGECAP) ? wd : '0;
      @(posedge clk);
      for (int b = 0; b < 3; b++) begin
         if (!reset_n) begin
            m_data[b] = '0;
            m_dir[b]  = '0;
            m_mask[b] = '0;
            m_cap[b]  = '0;
         end else begin
            // An input change becomes visible as a captured edge on the third edge after it.
            m_cap[b] = (m_cap[b] & ~clr) | edges(b, s[1], s[2]);
            if (wr) begin
               case (address)
                  ADDR_DATA:    m_data[b] = wd;
                  ADDR_DIR:     m_dir[b]  = wd;
                  ADDR_IRQMASK: m_mask[b] = wd;
                  ADDR_OUTSET:  m_data[b] = m_data[b] | wd;
                  ADDR_OUTCLR:  m_data[b] = m_data[b] & ~wd;
                  default: ;
               endcase
            end
         end
      end
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) s[k] = '0;
      end else begin
         s[3] = s[2];
         s[2] = s[1];
         s[1] = s[0];
         s[0] = in_port;
      end
      #1;
      check_all();
   endtask

   task automatic wr_reg(logic [2:0] a, logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd_chk(string tag, logic [2:0] a, logic [31:0] exp);
      address = a;
      #1;
      chk(tag, rd[0], exp);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = '0;

      // Reset state and a write swallowed by reset
      tick();
      tick();
      chk("rst_out_port", 32'(out_port[0]), 32'h0);
      chk("rst_out_en", 32'(out_en[0]), 32'h0);
      chk("rst_irq", 32'(irq[0]), 32'h0);
      for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
      wr_reg(ADDR_DATA, 32'h1234);
      chk("rst_write_ignored", 32'(out_port[0]), 32'h0);
      reset_n = 1'b1;
      tick();

      // Direction-mixed read of DATA, upper write bits dropped
      wr_reg(ADDR_DIR, 32'h00FF);
      wr_reg(ADDR_DATA, 32'hA5C3);
      in_port = 16'h5A00;
      repeat (3) tick();
      rd_chk("data_mix", ADDR_DATA, 32'h5AC3);
      wr_reg(ADDR_DATA, 32'hFFFF_A5C3);
      chk("data_upper_ignored", 32'(out_port[0]), 32'hA5C3);

      // Back-to-back atomic set then clear
      wr_reg(ADDR_DATA, 32'h00F0);
      wr_reg(ADDR_OUTSET, 32'h0F00);
      chk("outset", 32'(out_port[0]), 32'h0FF0);
      wr_reg(ADDR_OUTCLR, 32'h0030);
      chk("outclr", 32'(out_port[0]), 32'h0FC0);
      rd_chk("outset_reads0", ADDR_OUTSET, 32'h0);

      // Rising edge on bit 0 shows up on the third edge together with irq
      in_port = '0;
      repeat (4) tick();
      wr_reg(ADDR_EDGECAP, 32'hFFFF);
      wr_reg(ADDR_IRQMASK, 32'h0001);
      in_port[0] = 1'b1;
      address = ADDR_EDGECAP;
      tick();
      tick();
      chk("cap_not_early", rd[0], 32'h0);
      chk("irq_not_early", 32'(irq[0]), 32'h0);
      tick();
      chk("cap_bit0", rd[0], 32'h0001);
      chk("irq_bit0", 32'(irq[0]), 32'h1);
      wr_reg(ADDR_EDGECAP, 32'h0001);
      chk("cap_cleared", rd[0], 32'h0);
      chk("irq_cleared", 32'(irq[0]), 32'h0);

      // Masked capture, then unmask, then clear colliding with a new edge
      wr_reg(ADDR_IRQMASK, 32'h0000);
      in_port[4] = 1'b1;
      repeat (3) tick();
      rd_chk("cap_bit4_masked", ADDR_EDGECAP, 32'h0010);
      chk("irq_masked", 32'(irq[0]), 32'h0);
      wr_reg(ADDR_IRQMASK, 32'h0010);
      chk("irq_unmasked", 32'(irq[0]), 32'h1);
      in_port[4] = 1'b0;
      repeat (3) tick();
      in_port[4] = 1'b1;
      tick();
      tick();
      wr_reg(ADDR_EDGECAP, 32'h0010);
      chk("collision_set_wins", rd[0], 32'h0010);
      chk("collision_irq", 32'(irq[0]), 32'h1);
      wr_reg(ADDR_EDGECAP, 32'h0010);
      chk("clear_after_collision", rd[0], 32'h0);

      // Falling and rising edge on bit 2 across the three builds
      in_port[2] = 1'b1;
      repeat (4) tick();
      wr_reg(ADDR_EDGECAP, 32'hFFFF);
      in_port[2] = 1'b0;
      repeat (3) tick();
      address = ADDR_EDGECAP;
      #1;
      chk("rise_build_fall", rd[0] & 32'h4, 32'h0);
      chk("fall_build_fall", rd[1] & 32'h4, 32'h4);
      chk("any_build_fall", rd[2] & 32'h4, 32'h4);
      wr_reg(ADDR_EDGECAP, 32'hFFFF);
      in_port[2] = 1'b1;
      repeat (3) tick();
      chk("fall_build_rise", rd[1] & 32'h4, 32'h0);
      chk("any_build_rise", rd[2] & 32'h4, 32'h4);
      chk("rise_build_rise", rd[0] & 32'h4, 32'h4);

      // Random bus traffic, input toggling and occasional mid-operation reset
      for (int i = 0; i < 400; i++) begin
         reset_n    = ($urandom_range(0, 49) != 0);
         address    = 3'($urandom);
         chipselect = 1'($urandom);
         write_n    = 1'($urandom);
         writedata  = $urandom;
         if ($urandom_range(0, 2) == 0) in_port = 16'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
